// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine driver and matcher.
`timescale 1ns/1ps
package sme_pkg;

  localparam int unsigned DEF_STR_MAX = 32;
  localparam int unsigned DEF_PAT_MAX = 8;
  localparam int unsigned DEF_TIMEOUT = 1024;
  localparam int unsigned SW          = $clog2(DEF_STR_MAX);
  localparam int unsigned PW          = $clog2(DEF_PAT_MAX) + 1;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT,
    ST_DONE
  } sme_state_e;

endpackage

// File: rtl/sme_driver_if.sv
// Character stream and result link between the driver and the matcher.
`timescale 1ns/1ps
interface sme_driver_if;
  import sme_pkg::*;

  logic [7:0]    chardata;
  logic          isstring;
  logic          ispattern;
  logic          sme_match;
  logic [SW-1:0] sme_match_index;
  logic          sme_valid;

  modport master (
    output chardata, isstring, ispattern,
    input  sme_match, sme_match_index, sme_valid
  );

  modport slave (
    input  chardata, isstring, ispattern,
    output sme_match, sme_match_index, sme_valid
  );
endinterface

// File: rtl/sme_char_buf.sv
// Append-only character buffer with clear and random-index read.
`timescale 1ns/1ps
module sme_char_buf #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IW    = $clog2(DEPTH),
  localparam int unsigned LW    = IW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] len,
  output logic          full
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [LW-1:0] len_q, len_d;

  assign full    = (len_q == LW'(DEPTH));
  assign len     = len_q;
  assign rd_data = mem_q[rd_idx];

  // Writes past the end are silently dropped; the caller flags them.
  always_comb begin
    mem_d = mem_q;
    len_d = len_q;
    if (clr) begin
      len_d = '0;
    end else if (wr_en && !full) begin
      mem_d[len_q[IW-1:0]] = wr_data;
      len_d = len_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      len_q <= len_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/sme_driver.sv
// Host-side transmitter: buffers string/pattern, streams them to the matcher, returns one result beat.
`timescale 1ns/1ps
module sme_driver
  import sme_pkg::*;
#(
  parameter int unsigned STR_MAX = DEF_STR_MAX,
  parameter int unsigned PAT_MAX = DEF_PAT_MAX,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  input  logic          start,
  input  logic          keep_str,
  output logic          busy,
  output logic          wr_err,
  output logic          res_valid,
  output logic          res_match,
  output logic [SW-1:0] res_index,
  output logic          res_timeout,
  output logic          res_err,
  sme_driver_if.master  sme
);

  localparam int unsigned SIW = $clog2(STR_MAX);
  localparam int unsigned SLW = SIW + 1;
  localparam int unsigned PIW = $clog2(PAT_MAX);
  localparam int unsigned PLW = PIW + 1;
  localparam int unsigned TW  = $clog2(TIMEOUT);

  sme_state_e    state_q, state_d;
  logic [SLW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          str_sent_q, str_sent_d;
  logic          busy_q, busy_d;
  logic          wr_err_q, wr_err_d;
  logic [7:0]    chardata_q, chardata_d;
  logic          isstring_q, isstring_d;
  logic          ispattern_q, ispattern_d;
  logic          res_valid_q, res_valid_d;
  logic          res_match_q, res_match_d;
  logic [SW-1:0] res_index_q, res_index_d;
  logic          res_timeout_q, res_timeout_d;
  logic          res_err_q, res_err_d;

  logic           idle, start_ok;
  logic [7:0]     str_rd_data, pat_rd_data;
  logic [SLW-1:0] slen;
  logic [PLW-1:0] plen;
  logic           str_full, pat_full;

  assign idle = (state_q == ST_IDLE);

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && !wr_sel && idle),
    .wr_data (wr_data),
    .clr     (clr && idle),
    .rd_idx  ((state_q == ST_SEND_STR) ? SIW'(idx_q) : '0),
    .rd_data (str_rd_data),
    .len     (slen),
    .full    (str_full)
  );

  // Pattern is consumed by each job, so it is also cleared on the result beat.
  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && wr_sel && idle),
    .wr_data (wr_data),
    .clr     ((clr && idle) || (state_q == ST_DONE)),
    .rd_idx  ((state_q == ST_SEND_PAT) ? PIW'(idx_q) : '0),
    .rd_data (pat_rd_data),
    .len     (plen),
    .full    (pat_full)
  );

  assign start_ok = (plen != '0) && (keep_str ? str_sent_q : (slen != '0));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    str_sent_d    = str_sent_q;
    wr_err_d      = wr_err_q;
    chardata_d    = 8'h00;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_match_d   = 1'b0;
    res_index_d   = '0;
    res_timeout_d = 1'b0;
    res_err_d     = 1'b0;

    if (wr_en && (!idle || (wr_sel ? pat_full : str_full))) wr_err_d = 1'b1;
    if (clr && idle) wr_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!start_ok) begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
          end else if (keep_str) begin
            state_d     = ST_SEND_PAT;
            chardata_d  = pat_rd_data;
            ispattern_d = 1'b1;
            idx_d       = SLW'(1);
          end else begin
            state_d    = ST_SEND_STR;
            chardata_d = str_rd_data;
            isstring_d = 1'b1;
            idx_d      = SLW'(1);
          end
        end
      end
      ST_SEND_STR: begin
        if (idx_q == slen) begin
          state_d     = ST_SEND_PAT;
          str_sent_d  = 1'b1;
          chardata_d  = pat_rd_data;
          ispattern_d = 1'b1;
          idx_d       = SLW'(1);
        end else begin
          chardata_d = str_rd_data;
          isstring_d = 1'b1;
          idx_d      = idx_q + SLW'(1);
        end
      end
      ST_SEND_PAT: begin
        if (idx_q == SLW'(plen)) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end else begin
          chardata_d  = pat_rd_data;
          ispattern_d = 1'b1;
          idx_d       = idx_q + SLW'(1);
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A valid arriving on the expiry cycle still counts as a real result.
        if (sme.sme_valid) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          res_match_d = sme.sme_match;
          res_index_d = sme.sme_match_index;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d       = ST_DONE;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      str_sent_q    <= 1'b0;
      busy_q        <= 1'b0;
      wr_err_q      <= 1'b0;
      chardata_q    <= 8'h00;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      str_sent_q    <= str_sent_d;
      busy_q        <= busy_d;
      wr_err_q      <= wr_err_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
      res_err_q     <= res_err_d;
    end
  end

  assign busy          = busy_q;
  assign wr_err        = wr_err_q;
  assign sme.chardata  = chardata_q;
  assign sme.isstring  = isstring_q;
  assign sme.ispattern = ispattern_q;
  assign res_valid     = res_valid_q;
  assign res_match     = res_match_q;
  assign res_index     = res_index_q;
  assign res_timeout   = res_timeout_q;
  assign res_err       = res_err_q;

endmodule

// File: tb/tb_sme_driver.sv
// Directed bench for sme_driver: streaming order, result beat, errors, timeout, overflow, reset.
`timescale 1ns/1ps
module tb_sme_driver;
  import sme_pkg::*;

  localparam int unsigned TMO = 1024;

  logic          clk;
  logic          reset;
  logic          wr_en, wr_sel, clr, start, keep_str;
  logic [7:0]    wr_data;
  logic          busy, wr_err, res_valid, res_match, res_timeout, res_err;
  logic [SW-1:0] res_index;

  int n_cmp = 0;
  int n_err = 0;

  sme_driver_if sme_if ();

  sme_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .clr         (clr),
    .start       (start),
    .keep_str    (keep_str),
    .busy        (busy),
    .wr_err      (wr_err),
    .res_valid   (res_valid),
    .res_match   (res_match),
    .res_index   (res_index),
    .res_timeout (res_timeout),
    .res_err     (res_err),
    .sme         (sme_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr_text(input logic sel, input string s);
    for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic launch(input logic keep);
    start = 1'b1; keep_str = keep;
    tick();
    start = 1'b0; keep_str = 1'b0;
  endtask

  // Exact back-to-back string chars, then pattern chars, then quiet WAIT.
  task automatic expect_stream(input string s, input string p);
    for (int i = 0; i < s.len(); i++) begin
      expect_eq($sformatf("str_beat[%0d]", i),
                {22'd0, sme_if.isstring, sme_if.ispattern, sme_if.chardata}, {22'd0, 2'b10, s[i]});
      tick();
    end
    for (int i = 0; i < p.len(); i++) begin
      expect_eq($sformatf("pat_beat[%0d]", i),
                {22'd0, sme_if.isstring, sme_if.ispattern, sme_if.chardata}, {22'd0, 2'b01, p[i]});
      tick();
    end
    expect_eq("wait_quiet", {22'd0, sme_if.isstring, sme_if.ispattern, sme_if.chardata}, 32'd0);
    expect_eq("wait_busy", busy, 1);
  endtask

  task automatic respond(input logic m, input logic [SW-1:0] idx);
    sme_if.sme_valid = 1'b1; sme_if.sme_match = m; sme_if.sme_match_index = idx;
    tick();
    sme_if.sme_valid = 1'b0; sme_if.sme_match = 1'b0; sme_if.sme_match_index = '0;
    expect_eq("res_valid", res_valid, 1);
    expect_eq("res_match", res_match, m);
    expect_eq("res_index", res_index, idx);
    expect_eq("res_timeout", res_timeout, 0);
    expect_eq("res_err", res_err, 0);
    expect_eq("busy_on_beat", busy, 1);
    tick();
    expect_eq("res_valid_drop", res_valid, 0);
    expect_eq("busy_drop", busy, 0);
  endtask

  initial begin
    int    n;
    string s_exp, p_exp;

    reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = 8'h00;
    clr = 1'b0; start = 1'b0; keep_str = 1'b0;
    sme_if.sme_valid = 1'b0; sme_if.sme_match = 1'b0; sme_if.sme_match_index = '0;
    repeat (3) tick();

    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_wr_err", wr_err, 0);
    expect_eq("rst_chardata", sme_if.chardata, 0);
    expect_eq("rst_isstring", sme_if.isstring, 0);
    expect_eq("rst_ispattern", sme_if.ispattern, 0);
    expect_eq("rst_res", {27'd0, res_valid, res_match, res_timeout, res_err}, 0);
    expect_eq("rst_res_index", res_index, 0);
    reset = 1'b1;
    tick();

    // Job 1: full string + pattern, match at index 3.
    wr_text(1'b0, "ab cd");
    wr_text(1'b1, "cd");
    launch(1'b0);
    expect_stream("ab cd", "cd");
    respond(1'b1, 5'd3);

    // Job 2: reuse string; pattern buffer must have been emptied by job 1.
    wr_text(1'b1, "^a");
    launch(1'b1);
    expect_stream("", "^a");
    respond(1'b1, 5'd17);

    // Job 3: empty pattern is refused on the spot.
    launch(1'b0);
    expect_eq("err_valid", res_valid, 1);
    expect_eq("err_flag", res_err, 1);
    expect_eq("err_busy", busy, 1);
    expect_eq("err_strobes", {30'd0, sme_if.isstring, sme_if.ispattern}, 0);
    expect_eq("err_match", res_match, 0);
    tick();
    expect_eq("err_valid_drop", res_valid, 0);
    expect_eq("err_busy_drop", busy, 0);
    expect_eq("err_strobes_after", {30'd0, sme_if.isstring, sme_if.ispattern}, 0);

    // Job 4: matcher silent -> timeout exactly TMO cycles after WAIT entry.
    wr(1'b1, "x");
    launch(1'b1);
    expect_stream("", "x");
    n = 0;
    while (!res_valid && n < 2000) begin
      tick();
      n++;
    end
    expect_eq("timeout_latency", n, TMO);
    expect_eq("timeout_flag", res_timeout, 1);
    expect_eq("timeout_match", res_match, 0);
    expect_eq("timeout_index", res_index, 0);
    expect_eq("timeout_err", res_err, 0);
    tick();
    expect_eq("timeout_busy_drop", busy, 0);

    // Job 5: valid on the expiry cycle wins; a write while busy is flagged.
    wr(1'b1, "y");
    launch(1'b1);
    expect_stream("", "y");
    wr(1'b0, 8'h7A);
    repeat (TMO - 2) tick();
    sme_if.sme_valid = 1'b1; sme_if.sme_match = 1'b1; sme_if.sme_match_index = 5'd9;
    tick();
    sme_if.sme_valid = 1'b0; sme_if.sme_match = 1'b0; sme_if.sme_match_index = '0;
    expect_eq("race_valid", res_valid, 1);
    expect_eq("race_timeout", res_timeout, 0);
    expect_eq("race_match", res_match, 1);
    expect_eq("race_index", res_index, 9);
    tick();
    expect_eq("busy_write_err", wr_err, 1);
    do_clr();
    expect_eq("clr_wr_err", wr_err, 0);

    // Job 6: overflow of both buffers; contents must be intact.
    s_exp = "";
    p_exp = "";
    for (int i = 0; i < 32; i++) begin
      wr(1'b0, 8'h40 + 8'(i));
      s_exp = {s_exp, $sformatf("%c", 8'h40 + 8'(i))};
    end
    expect_eq("str_full_no_err", wr_err, 0);
    wr(1'b0, 8'hFF);
    expect_eq("str_overflow_err", wr_err, 1);
    for (int i = 0; i < 8; i++) begin
      wr(1'b1, 8'h61 + 8'(i));
      p_exp = {p_exp, $sformatf("%c", 8'h61 + 8'(i))};
    end
    wr(1'b1, 8'hFF);
    expect_eq("pat_overflow_err", wr_err, 1);
    launch(1'b0);
    expect_stream(s_exp, p_exp);
    respond(1'b0, 5'd0);
    expect_eq("wr_err_sticky", wr_err, 1);
    do_clr();
    expect_eq("wr_err_cleared", wr_err, 0);

    // Job 7: reset mid string phase, then keep_str has nothing to reuse.
    wr_text(1'b0, "hello");
    wr_text(1'b1, "lo");
    launch(1'b0);
    expect_eq("pre_rst_beat", {22'd0, sme_if.isstring, sme_if.ispattern, sme_if.chardata},
              {22'd0, 2'b10, 8'h68});
    tick();
    #2 reset = 1'b0;
    #1;
    expect_eq("midrst_isstring", sme_if.isstring, 0);
    expect_eq("midrst_busy", busy, 0);
    expect_eq("midrst_chardata", sme_if.chardata, 0);
    tick();
    reset = 1'b1;
    tick();
    wr(1'b1, "a");
    launch(1'b1);
    expect_eq("post_rst_keep_valid", res_valid, 1);
    expect_eq("post_rst_keep_err", res_err, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
